uart_tx_param: RTL
==================

# uart_tx_param

Parametrised UART transmitter with an input FIFO, a valid/ready write interface, runtime-selectable parity (none/even/odd) and one or two stop bits. It is the next-generation transmit side of the UART path. Upstream logic pushes words into the FIFO. The block serialises them LSB-first on `tx`, paced by an external one-cycle `baud_tick` strobe. Frames are sent back-to-back with no idle gap while the FIFO holds data.

## Interface
- `DATA_W`, default 8: data bits per frame; legal range 5..9.
- `FIFO_DEPTH`, default 4: FIFO entries; power of two, at least 2.
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-low.
- `baud_tick`  in  1  one-cycle strobe marking each bit-period boundary.
- `s_data`  in  DATA_W  word to transmit.
- `s_valid`  in  1  `s_data` is valid.
- `s_ready`  out  1  FIFO not full; a push occurs when `s_valid && s_ready`.
- `parity_mode`  in  2  00 none, 01 even, 10 odd, 11 none.
- `stop2`  in  1  1 selects two stop bits, 0 selects one.
- `tx`  out  1  serial line, idle high.
- `busy`  out  1  high when the FSM is not in IDLE.
- `fifo_count`  out  $clog2(FIFO_DEPTH+1)  current FIFO occupancy.

## Operation
- **Reset** (`reset`=0 sampled at a `clk` edge): from the next cycle, `tx`=1, `busy`=0, `s_ready`=1, `fifo_count`=0.
  - FIFO is flushed and the FSM returns to IDLE.
  - The bit counter and the stop counter are cleared.
  - A frame in progress is aborted immediately; no partial stop bit is sent.
- **FIFO**: registered, synchronous.
  - `s_ready` = (`fifo_count` != `FIFO_DEPTH`). It does not depend on a same-cycle pop, so no push is accepted when full, even if a pop occurs that cycle.
  - A pop is based on registered non-empty status. A word pushed into an empty FIFO cannot be popped in the same cycle.
  - A simultaneous push and pop leaves `fifo_count` unchanged.
- **Frame launch**: on a cycle with `baud_tick`=1, and either (IDLE, or final STOP bit completing) with the FIFO non-empty:
  - pop the head word into a shift register;
  - latch `parity_mode` and `stop2` for the whole frame;
  - `tx`<=0;
  - go to START.
- **FSM**: all transitions and all `tx` updates occur only on cycles with `baud_tick`=1.
  - IDLE: `tx` stays 1. Exit only via frame launch.
  - START: `tx`<=d[0], bit counter<=0, go to DATA.
  - DATA, bit counter != `DATA_W`-1: `tx`<=d[counter+1], counter++.
  - DATA, bit counter == `DATA_W`-1, parity enabled: `tx`<=parity bit, go to PARITY.
  - DATA, bit counter == `DATA_W`-1, parity none: `tx`<=1, go to STOP.
  - PARITY: `tx`<=1, go to STOP.
  - STOP, `stop2`=1 and first stop bit: `tx` stays 1, stay in STOP.
  - STOP, final stop bit: frame launch if the FIFO is non-empty, otherwise go to IDLE with `tx`=1.
- **Parity bit**: even parity = XOR of the data bits; odd parity = inverse of that XOR.
- **Runtime config**: changes to `parity_mode` or `stop2` mid-frame have no effect until the next launch.

## Timing
- `tx` is a registered output and changes exactly one cycle after the qualifying `baud_tick` edge.
- Each bit lasts one baud interval (from `baud_tick` to `baud_tick`).
- Frame length in ticks = 1 + `DATA_W` + (1 if parity enabled) + (2 if `stop2`=1, else 1).
- Latency from push into an empty IDLE block to the start bit: at most one baud interval plus 2 cycles. The start bit begins on the first `baud_tick` at least one cycle after the push.
- `busy` rises with the start bit and falls with the return to IDLE after the final stop bit. In back-to-back operation `busy` stays high continuously.
- `fifo_count` updates the cycle after a push or pop.
- `baud_tick` held high continuously is legal: one bit per clock.

## Test plan
- **Single even-parity frame**: `DATA_W`=8, push 0xA5, `parity_mode`=01, `stop2`=0, `baud_tick` every 4 clocks.
  - Required `tx` per tick: 0, 1,0,1,0,0,1,0,1, 0, 1 (11 ticks), then idle high.
  - Repeat with `parity_mode`=10: parity bit = 1.
- **Back-to-back**: push 0x01, 0x80, 0xFF with `FIFO_DEPTH`=4, even parity, 1 stop.
  - Three contiguous 11-tick frames with no idle bit between them.
  - `busy` high for exactly 33 ticks.
  - `fifo_count` sequence after pushes: 3, then 2, 1, 0 at each launch.
- **FIFO full**: no `baud_tick`, hold `s_valid`=1 for 6 cycles.
  - `fifo_count` ends at 4; `s_ready`=0 after the 4th push.
  - Extra words are not stored; later transmission shows exactly the first 4 words.
- **Width / stop variant**: `DATA_W`=7, push 0x55, `parity_mode`=00, `stop2`=1.
  - Required `tx`: 0, 1,0,1,0,1,0,1, 1,1 (10 ticks).
- **Mid-frame config change**: toggle `stop2` and `parity_mode` during DATA bits.
  - Current frame keeps its launch settings; the next frame uses the new ones.
- **Reset mid-frame**: assert `reset`=0 during bit 3 with 2 words queued.
  - Next cycle: `tx`=1, `busy`=0, `fifo_count`=0, `s_ready`=1.
  - After release, no transmission occurs until a new push.

Source files
------------

// File: rtl/uart_tx_param.sv
// UART transmitter with a small input FIFO, selectable parity and one or two stop bits.
// Bits are paced by an external one-cycle baud_tick; queued frames go out back-to-back.
module uart_tx_param #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             baud_tick,
  input  logic [DATA_W-1:0]                s_data,
  input  logic                             s_valid,
  output logic                             s_ready,
  input  logic [1:0]                       parity_mode,
  input  logic                             stop2,
  output logic                             tx,
  output logic                             busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(DATA_W);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [DATA_W-1:0] shreg;
  logic [BW-1:0]     bit_cnt;
  logic              stop_cnt;
  logic              par_en;
  logic              par_bit;
  logic              stop2_lat;
  logic              push;
  logic              pop;
  logic              not_empty;
  logic              frame_end;
  logic              launch;

  // Ready looks only at the registered count, so a full FIFO refuses a push even while popping.
  assign s_ready   = (fifo_count != CW'(FIFO_DEPTH));
  assign not_empty = (fifo_count != '0);
  assign push      = s_valid && s_ready;
  assign frame_end = (state == STOP) && (!stop2_lat || stop_cnt);
  assign launch    = baud_tick && not_empty && ((state == IDLE) || frame_end);
  assign pop       = launch;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)
        fifo_count <= fifo_count + CW'(1);
      else if (pop && !push)
        fifo_count <= fifo_count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      tx        <= 1'b1;
      busy      <= 1'b0;
      shreg     <= '0;
      bit_cnt   <= '0;
      stop_cnt  <= 1'b0;
      par_en    <= 1'b0;
      par_bit   <= 1'b0;
      stop2_lat <= 1'b0;
    end else if (baud_tick) begin
      if (launch) begin
        // Frame settings are captured here and held until the next launch.
        shreg     <= mem[rd_ptr];
        par_en    <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
        par_bit   <= (^mem[rd_ptr]) ^ parity_mode[1];
        stop2_lat <= stop2;
        stop_cnt  <= 1'b0;
        tx        <= 1'b0;
        busy      <= 1'b1;
        state     <= START;
      end else begin
        case (state)
          IDLE: tx <= 1'b1;
          START: begin
            tx      <= shreg[0];
            shreg   <= shreg >> 1;
            bit_cnt <= '0;
            state   <= DATA;
          end
          DATA: begin
            if (bit_cnt != BW'(DATA_W - 1)) begin
              tx      <= shreg[0];
              shreg   <= shreg >> 1;
              bit_cnt <= bit_cnt + BW'(1);
            end else if (par_en) begin
              tx    <= par_bit;
              state <= PARITY;
            end else begin
              tx       <= 1'b1;
              stop_cnt <= 1'b0;
              state    <= STOP;
            end
          end
          PARITY: begin
            tx       <= 1'b1;
            stop_cnt <= 1'b0;
            state    <= STOP;
          end
          STOP: begin
            if (!frame_end) begin
              stop_cnt <= 1'b1;
            end else begin
              tx    <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
